// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter with registered grant; define ARB_TIMEOUT_EN to bound grants to HOLD_MAX cycles
module rr_arbiter4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_nx;
    logic [1:0] ptr, ptr_nx, idx_nx, pick;
    logic [3:0] gnt_nx;
    logic vld_nx, rel, expire;
    assign rel = done || !req[gnt_idx];
    always_comb begin
        pick = ptr;
        for (int i = 3; i >= 0; i--)
            if (req[ptr + 2'(i)]) pick = ptr + 2'(i);
    end
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        gnt_nx   = gnt;
        idx_nx   = gnt_idx;
        vld_nx   = gnt_vld;
        if (state == IDLE && req != 4'b0000) begin
            state_nx = GRANT;
            idx_nx   = pick;
            gnt_nx   = 4'b0001 << pick;
            vld_nx   = 1'b1;
        end else if (state == GRANT && (rel || expire)) begin
            state_nx = IDLE;
            gnt_nx   = 4'b0000;
            vld_nx   = 1'b0;
            ptr_nx   = gnt_idx + 2'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            gnt     <= 4'b0000;
            gnt_idx <= 2'd0;
            gnt_vld <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            gnt     <= gnt_nx;
            gnt_idx <= idx_nx;
            gnt_vld <= vld_nx;
        end
    end
`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt;
    assign expire = state == GRANT && cnt == 8'(HOLD_MAX);
    // a normal release on the expiry edge wins, so timeout only marks forced releases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 8'd0;
            timeout <= 1'b0;
        end else begin
            cnt     <= state_nx == GRANT ? (state == GRANT ? cnt + 8'd1 : 8'd1) : 8'd0;
            timeout <= expire && !rel;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: vector table, corner sequences and randomized run against a behavioural arbiter model
module tb_rr_arbiter4;
    localparam int HOLD = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    typedef struct {
        logic [3:0] r;
        logic       d;
        logic [3:0] g;
        logic [1:0] i;
        logic       v;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0, done = 1'b0;
    logic [3:0] req = 4'b0000, gnt;
    logic [1:0] gnt_idx;
    logic gnt_vld, timeout;
    int errors = 0, checks = 0;
    int m_ptr, m_idx, m_hold;
    bit m_vld, m_to;
    vec_t tbl[18];
    rr_arbiter4 #(.HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset;
        m_ptr = 0; m_idx = 0; m_vld = 0; m_to = 0; m_hold = 0;
    endtask
    task automatic model_edge(input logic [3:0] r, input logic d);
        m_to = 0;
        if (!m_vld) begin
            for (int i = 0; i < 4; i++)
                if (!m_vld && r[(m_ptr + i) % 4]) begin
                    m_idx = (m_ptr + i) % 4; m_vld = 1; m_hold = 1;
                end
        end else if (d || !r[m_idx]) begin
            m_vld = 0; m_ptr = (m_idx + 1) % 4;
        end else if (TO_EN && m_hold == HOLD) begin
            m_vld = 0; m_ptr = (m_idx + 1) % 4; m_to = 1;
        end else m_hold++;
    endtask
    task automatic chk_model(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), m_vld ? 32'(1 << m_idx) : 32'd0);
        chk({tag, ".vld"}, 32'(gnt_vld), 32'(m_vld));
        chk({tag, ".idx"}, 32'(gnt_idx), 32'(m_idx));
        chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask
    task automatic cyc(input logic [3:0] r, input logic d, input string tag);
        req = r; done = d;
        @(posedge clk);
        model_edge(r, d);
        #1 chk_model(tag);
    endtask
    task automatic do_reset;
        rst_n = 0; req = 0; done = 0;
        model_reset();
        #1 chk_model("rst");
        @(posedge clk);
        #1 rst_n = 1;
    endtask
    initial begin
        int n;
        logic [3:0] r;
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0};
        tbl[5]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        tbl[6]  = '{4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1};
        tbl[7]  = '{4'b1101, 1'b1, 4'b0000, 2'd2, 1'b0};
        tbl[8]  = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1};
        tbl[9]  = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1};
        tbl[10] = '{4'b0001, 1'b0, 4'b0000, 2'd3, 1'b0};
        tbl[11] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};
        tbl[13] = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[14] = '{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[15] = '{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0};
        tbl[17] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};
        do_reset();
        for (int k = 0; k < 5; k++) cyc(4'b0000, 1'b0, "idle");
        for (int k = 0; k < 18; k++) begin
            cyc(tbl[k].r, tbl[k].d, "tbl");
            chk($sformatf("tbl%0d.gnt", k), 32'(gnt), 32'(tbl[k].g));
            chk($sformatf("tbl%0d.idx", k), 32'(gnt_idx), 32'(tbl[k].i));
            chk($sformatf("tbl%0d.vld", k), 32'(gnt_vld), 32'(tbl[k].v));
        end
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(4'b1111, 1'b0, "order");
            chk($sformatf("order%0d.idx", k), 32'(gnt_idx), 32'(k % 4));
            cyc(4'b1111, 1'b0, "order");
            cyc(4'b1111, 1'b1, "order");
            chk($sformatf("order%0d.gap", k), 32'(gnt), 32'd0);
        end
        do_reset();
        cyc(4'b1000, 1'b0, "arst");
        chk("arst.own3", 32'(gnt), 32'h8);
        #3 rst_n = 0;
        model_reset();
        #1 chk("arst.async_gnt", 32'(gnt), 32'd0);
        chk_model("arst");
        @(posedge clk);
        #1 rst_n = 1;
        chk("arst.held", 32'(gnt_vld), 32'd0);
        cyc(4'b1010, 1'b0, "arst.after");
        chk("arst.after_idx", 32'(gnt_idx), 32'd1);
`ifdef ARB_TIMEOUT_EN
        do_reset();
        cyc(4'b0001, 1'b0, "to.grant");
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!gnt_vld) break;
            n++;
            cyc(4'b0001, 1'b0, "to.hold");
        end
        chk("to.len", 32'(n), 32'(HOLD));
        chk("to.pulse", 32'(timeout), 32'd1);
        cyc(4'b0001, 1'b0, "to.regrant");
        chk("to.regrant_gnt", 32'(gnt), 32'h1);
        chk("to.pulse_end", 32'(timeout), 32'd0);
        for (int k = 0; k < HOLD - 1; k++) cyc(4'b0001, 1'b0, "to.hold2");
        cyc(4'b0001, 1'b1, "to.done_at_expiry");
        chk("to.done_no_pulse", 32'(timeout), 32'd0);
`endif
        do_reset();
        r = 4'b0000;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cyc(r, $urandom_range(0, 5) == 0, "rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
